// File: rtl/pong_pkg.sv
// Shared types for the PIC link: frame width, decoded frame layouts and
// the receiver state encoding.
package pong_pkg;

    localparam int unsigned WORD_W = 32;

    // Frame carrying ball position and scores.
    typedef struct packed {
        logic [9:0] ballx;
        logic [9:0] bally;
        logic [5:0] score1;
        logic [5:0] score2;
    } frame_a_t;

    // Frame carrying paddle positions and sound selection.
    typedef struct packed {
        logic [9:0] paddle1;
        logic [9:0] paddle2;
        logic [8:0] sound_sel;
        logic [2:0] pad;
    } frame_b_t;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_e;

endpackage

// File: rtl/spi_frame_rx_sync_edge.sv
// Multi-stage synchronizer followed by a registered edge detector.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Next state: shift the pin into the chain and compare with last synced value.
    always_comb begin
        sync_d = (sync_q << 1) | SYNC_STAGES'(din);
        prev_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
    end

    // Synchronizer and edge pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI slave frame receiver/transmitter with inactivity timeout and
// vsync-aligned double-buffered publication of completed frames.
module spi_frame_rx #(
    parameter int unsigned WORD_W      = pong_pkg::WORD_W,
    parameter int unsigned TIMEOUT     = 4000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sck,
    input  logic              sdo,
    input  logic              vsync,
    input  logic [WORD_W-1:0] tx_data,
    output logic              sdi,
    output logic [WORD_W-1:0] q,
    output logic              q_valid,
    output logic [7:0]        frame_err,
    output logic              overrun
);
    import pong_pkg::*;

    localparam int unsigned CNT_W  = $clog2(WORD_W);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    logic sck_fall, vs_rise, sdo_s;
    logic publish;
    rx_state_e state;

    logic [SYNC_STAGES:0] sdo_dly_q, sdo_dly_d;
    logic [WORD_W-2:0]    rx_sr_q, rx_sr_d;
    logic [WORD_W-1:0]    tx_sr_q, tx_sr_d;
    logic [WORD_W-1:0]    pending_q, pending_d;
    logic [WORD_W-1:0]    q_q, q_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic [7:0]           frame_err_q, frame_err_d;
    logic                 pend_full_q, pend_full_d;
    logic                 overrun_q, overrun_d;
    logic                 q_valid_q, q_valid_d;
    logic                 sdi_q, sdi_d;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sck),
        .dout  (),
        .rise  (),
        .fall  (sck_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_vsync_sync (
        .clk   (clk),
        .reset (reset),
        .din   (vsync),
        .dout  (),
        .rise  (vs_rise),
        .fall  ()
    );

    // sdo takes one extra stage to line up with the registered sck edge pulse.
    assign sdo_s   = sdo_dly_q[SYNC_STAGES];
    assign state   = (bit_cnt_q == '0) ? RX_IDLE : RX_SHIFT;
    assign publish = vs_rise & pend_full_q;

    // Receive, transmit, timeout and publish decisions for the next cycle.
    always_comb begin
        sdo_dly_d   = {sdo_dly_q[SYNC_STAGES-1:0], sdo};
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        pending_d   = pending_q;
        q_d         = q_q;
        bit_cnt_d   = bit_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        frame_err_d = frame_err_q;
        pend_full_d = pend_full_q;
        overrun_d   = overrun_q;
        q_valid_d   = publish;
        sdi_d       = sdi_q;

        // Publish first so a frame completing in the same cycle refills the buffer.
        if (publish) begin
            q_d         = pending_q;
            pend_full_d = 1'b0;
        end

        if (state == RX_IDLE) begin
            tx_sr_d = tx_data;
        end

        if (sck_fall) begin
            sdi_d      = tx_sr_q[WORD_W-1];
            tx_sr_d    = tx_sr_q << 1;
            rx_sr_d    = {rx_sr_q[WORD_W-3:0], sdo_s};
            idle_cnt_d = '0;
            if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
                pending_d   = {rx_sr_q, sdo_s};
                pend_full_d = 1'b1;
                bit_cnt_d   = '0;
                if (pend_full_q && !publish) begin
                    overrun_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end else if (state == RX_SHIFT) begin
            if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
                bit_cnt_d  = '0;
                idle_cnt_d = '0;
                if (frame_err_q != 8'hFF) begin
                    frame_err_d = frame_err_q + 8'd1;
                end
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end else begin
            idle_cnt_d = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sdo_dly_q   <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            pending_q   <= '0;
            q_q         <= '0;
            bit_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            frame_err_q <= '0;
            pend_full_q <= 1'b0;
            overrun_q   <= 1'b0;
            q_valid_q   <= 1'b0;
            sdi_q       <= 1'b0;
        end else begin
            sdo_dly_q   <= sdo_dly_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            pending_q   <= pending_d;
            q_q         <= q_d;
            bit_cnt_q   <= bit_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            frame_err_q <= frame_err_d;
            pend_full_q <= pend_full_d;
            overrun_q   <= overrun_d;
            q_valid_q   <= q_valid_d;
            sdi_q       <= sdi_d;
        end
    end

    assign sdi       = sdi_q;
    assign q         = q_q;
    assign q_valid   = q_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Bench for spi_frame_rx: pin-level frame model with fixed sync latency,
// checked every cycle, plus directed literal checks.
module tb_spi_frame_rx;

    localparam int unsigned TO   = 64;
    localparam int unsigned HALF = 4;
    localparam int unsigned LAT  = 3;

    logic        clk;
    logic        reset;
    logic        sck;
    logic        sdo;
    logic        vsync;
    logic [31:0] tx_data;
    logic        sdi;
    logic [31:0] q;
    logic        q_valid;
    logic [7:0]  frame_err;
    logic        overrun;

    int unsigned total;
    int unsigned bad;
    int unsigned qv_count;

    spi_frame_rx #(
        .WORD_W      (32),
        .TIMEOUT     (TO),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sck       (sck),
        .sdo       (sdo),
        .vsync     (vsync),
        .tx_data   (tx_data),
        .sdi       (sdi),
        .q         (q),
        .q_valid   (q_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: pin samples per clock (bit k = k edges ago) and frame bookkeeping.
    logic [LAT+1:0] sck_h, vs_h, sdo_h;
    logic [31:0]    m_word, m_pend, m_q, m_txw, tx_prev;
    logic           m_full, m_qv, m_ovr, m_sdi;
    logic [7:0]     m_ferr;
    int unsigned    m_nbits, cyc, last_fall;
    logic           fall_ev, vrise_ev;

    initial begin
        sck_h = '0; vs_h = '0; sdo_h = '0;
        m_word = '0; m_pend = '0; m_q = '0; m_txw = '0; tx_prev = '0;
        m_full = 1'b0; m_qv = 1'b0; m_ovr = 1'b0; m_sdi = 1'b0; m_ferr = '0;
        m_nbits = 0; cyc = 0; last_fall = 0;
    end

    // Model: a pin event seen on sample edge m takes effect on edge m+LAT.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            sck_h = '0; vs_h = '0; sdo_h = '0;
            m_word = '0; m_pend = '0; m_q = '0;
            m_full = 1'b0; m_qv = 1'b0; m_ovr = 1'b0; m_sdi = 1'b0; m_ferr = '0;
            m_nbits = 0;
        end else begin
            sck_h = {sck_h[LAT:0], sck};
            vs_h  = {vs_h[LAT:0], vsync};
            sdo_h = {sdo_h[LAT:0], sdo};
            fall_ev  = sck_h[LAT+1] && !sck_h[LAT];
            vrise_ev = !vs_h[LAT+1] && vs_h[LAT];
            m_qv = 1'b0;
            if (vrise_ev && m_full) begin
                m_q    = m_pend;
                m_qv   = 1'b1;
                m_full = 1'b0;
            end
            if (fall_ev) begin
                if (m_nbits == 0) m_txw = tx_prev;
                m_sdi     = m_txw[31 - m_nbits];
                m_word    = {m_word[30:0], sdo_h[LAT]};
                m_nbits   = m_nbits + 1;
                last_fall = cyc;
                if (m_nbits == 32) begin
                    if (m_full) m_ovr = 1'b1;
                    m_pend  = m_word;
                    m_full  = 1'b1;
                    m_nbits = 0;
                end
            end else if (m_nbits != 0 && cyc - last_fall == TO) begin
                m_nbits = 0;
                if (m_ferr != 8'd255) m_ferr = m_ferr + 8'd1;
            end
        end
        tx_prev = tx_data;
        #1;
        total = total + 5;
        if (q !== m_q) begin
            bad = bad + 1;
            $display("FAIL cyc_q @%0d: got %h want %h", cyc, q, m_q);
        end
        if (q_valid !== m_qv) begin
            bad = bad + 1;
            $display("FAIL cyc_q_valid @%0d: got %b want %b", cyc, q_valid, m_qv);
        end
        if (frame_err !== m_ferr) begin
            bad = bad + 1;
            $display("FAIL cyc_frame_err @%0d: got %0d want %0d", cyc, frame_err, m_ferr);
        end
        if (overrun !== m_ovr) begin
            bad = bad + 1;
            $display("FAIL cyc_overrun @%0d: got %b want %b", cyc, overrun, m_ovr);
        end
        if (sdi !== m_sdi) begin
            bad = bad + 1;
            $display("FAIL cyc_sdi @%0d: got %b want %b", cyc, sdi, m_sdi);
        end
        if (q_valid === 1'b1) qv_count = qv_count + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One SPI bit: data and sck rise together, sck falls HALF cycles later.
    task automatic send_bit(input logic b, input logic raise_vs, output logic seen);
        sdo = b;
        sck = 1'b1;
        if (raise_vs) vsync = 1'b0;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
        if (raise_vs) vsync = 1'b1;
        repeat (HALF) @(negedge clk);
        seen = sdi;
    endtask

    task automatic send_word(input logic [31:0] w, input int unsigned n, input logic vs_last,
                             output logic [31:0] seen_word);
        logic s;
        logic [31:0] tmp;
        tmp = '0;
        for (int unsigned i = 0; i < n; i++) begin
            send_bit(w[31 - i], vs_last && (i == n - 1), s);
            tmp = {tmp[30:0], s};
        end
        seen_word = tmp;
    endtask

    task automatic pulse_vsync();
        vsync = 1'b0;
        repeat (4) @(negedge clk);
        vsync = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    logic [31:0] sw;
    int unsigned qv0;

    initial begin
        total = 0; bad = 0; qv_count = 0;
        reset = 1'b1; sck = 1'b0; sdo = 1'b0; vsync = 1'b1; tx_data = '0;
        repeat (3) @(negedge clk);
        check("rst_q", q, 32'h0);
        check("rst_q_valid", {31'd0, q_valid}, 32'h0);
        check("rst_frame_err", {24'd0, frame_err}, 32'h0);
        check("rst_overrun", {31'd0, overrun}, 32'h0);
        check("rst_sdi", {31'd0, sdi}, 32'h0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // Basic frame and publish.
        qv0 = qv_count;
        send_word(32'hA5C3_0F96, 32, 1'b0, sw);
        check("t1_q_before_vsync", q, 32'h0);
        pulse_vsync();
        check("t1_q", q, 32'hA5C3_0F96);
        check("t1_pulses", qv_count - qv0, 32'd1);
        check("t1_frame_err", {24'd0, frame_err}, 32'h0);
        check("t1_overrun", {31'd0, overrun}, 32'h0);

        // Transmit sequence.
        tx_data = 32'h8000_0001;
        repeat (2) @(negedge clk);
        send_word(32'hDEAD_BEEF, 32, 1'b0, sw);
        check("t2_sdi_seq", sw, 32'h8000_0001);
        pulse_vsync();
        check("t2_q", q, 32'hDEAD_BEEF);

        // Reloaded tx word, partial frame, timeout, then a good frame.
        tx_data = 32'h7FFF_FFFF;
        repeat (2) @(negedge clk);
        send_word(32'hFFFF_0000, 17, 1'b0, sw);
        check("t3_sdi_reload", sw & 32'h0001_FFFF, 32'h0000_FFFF);
        repeat (TO + 10) @(negedge clk);
        check("t3_frame_err_abort", {24'd0, frame_err}, 32'd1);
        send_word(32'h1234_5678, 32, 1'b0, sw);
        pulse_vsync();
        check("t3_q", q, 32'h1234_5678);
        check("t3_frame_err", {24'd0, frame_err}, 32'd1);

        // Frame completion coincident with vsync rise.
        send_word(32'hAAAA_AAAA, 32, 1'b0, sw);
        qv0 = qv_count;
        send_word(32'h5555_5555, 32, 1'b1, sw);
        repeat (6) @(negedge clk);
        check("t5_q_old_pending", q, 32'hAAAA_AAAA);
        check("t5_pulses", qv_count - qv0, 32'd1);
        check("t5_no_overrun", {31'd0, overrun}, 32'h0);
        pulse_vsync();
        check("t5_q_new", q, 32'h5555_5555);

        // Overrun.
        send_word(32'h1111_1111, 32, 1'b0, sw);
        check("t4_overrun_clear", {31'd0, overrun}, 32'h0);
        send_word(32'h2222_2222, 32, 1'b0, sw);
        pulse_vsync();
        check("t4_overrun", {31'd0, overrun}, 32'h1);
        check("t4_q", q, 32'h2222_2222);

        // Reset in the middle of a frame.
        qv0 = qv_count;
        send_word(32'hFFFF_FFFF, 20, 1'b0, sw);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_rst_q", q, 32'h0);
        check("t6_rst_q_valid", {31'd0, q_valid}, 32'h0);
        check("t6_rst_frame_err", {24'd0, frame_err}, 32'h0);
        check("t6_rst_overrun", {31'd0, overrun}, 32'h0);
        check("t6_rst_sdi", {31'd0, sdi}, 32'h0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("t6_no_publish", qv_count - qv0, 32'd0);
        send_word(32'h0F0F_0F0F, 32, 1'b0, sw);
        pulse_vsync();
        check("t6_q", q, 32'h0F0F_0F0F);
        check("t6_pulses", qv_count - qv0, 32'd1);

        // frame_err saturation.
        for (int unsigned k = 0; k < 256; k++) begin
            send_word(32'h8000_0000, 1, 1'b0, sw);
            repeat (TO + 8) @(negedge clk);
        end
        check("sat_frame_err", {24'd0, frame_err}, 32'd255);
        check("sat_q_hold", q, 32'h0F0F_0F0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
